// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
//   rx_state_t    : receiver FSM states
//   parity_mode_t : encoding of the Parity_Mode input (3 behaves as none)
//   ERR_*         : bit positions inside Rx_Error
//   majority3     : 2-of-3 vote used for bit recovery
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP1    = 3'd4,
    ST_STOP2    = 3'd5,
    ST_DONE     = 3'd6,
    ST_BRK_WAIT = 3'd7
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_t;

  localparam int unsigned ERR_OVR = 3;
  localparam int unsigned ERR_BRK = 2;
  localparam int unsigned ERR_PAR = 1;
  localparam int unsigned ERR_FRM = 0;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud tick generator: counts 0..div and pulses tick_c on the wrap cycle.
//   Clk, Rst_N : clock, async active-low reset
//   restart    : force the counter back to 0 (start-edge alignment)
//   div        : terminal count; div=0 ticks every clock
//   tick_c     : combinational one-clock tick pulse
module uart_baud_tick #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst_N,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick_c
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;

  assign tick_c = (cnt_q == div);

  // Next count: wrap on tick, realign on restart.
  always_comb begin
    cnt_d = cnt_q + DIV_WIDTH'(1);
    if (restart || tick_c) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote, runtime parity
// and stop-bit selection, and a valid/ack holding register with error flags.
//   Clk, Rst_N   : clock, async active-low reset
//   Rx_In        : raw serial line (idle high), synchronised internally
//   Baud_Div     : one baud tick every Baud_Div+1 clocks
//   Parity_Mode  : 0 none, 1 even, 2 odd, 3 none
//   Two_Stop     : 1 selects two stop bits
//   Rx_Ack       : consumer accepts the held frame
//   Data_Rdy_Out : holding register valid
//   Rx_Data_Out  : received data word
//   Rx_Error     : {overrun, break, parity, framing}
//   RTS          : inverse of Data_Rdy_Out
//   Busy         : receiver FSM not idle
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                 Clk,
  input  logic                 Rst_N,
  input  logic                 Rx_In,
  input  logic [DIV_WIDTH-1:0] Baud_Div,
  input  logic [1:0]           Parity_Mode,
  input  logic                 Two_Stop,
  input  logic                 Rx_Ack,
  output logic                 Data_Rdy_Out,
  output logic [DATA_BITS-1:0] Rx_Data_Out,
  output logic [3:0]           Rx_Error,
  output logic                 RTS,
  output logic                 Busy
);

  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  localparam logic [OS_W-1:0]  OS_S0    = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_S1    = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  OS_S2    = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  // Line synchroniser and edge history
  logic sync1_q, sync2_q, line_prev_q;
  logic line;

  rx_state_t state_q, state_d;

  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop1_q, stop1_d;
  logic                 frm_err_q, frm_err_d;
  logic                 hi_run_q, hi_run_d;

  // Frame configuration captured at the start edge
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 two_q, two_d;

  // Holding register and registered outputs
  logic                 rdy_q, rdy_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [3:0]           err_q, err_d;
  logic                 rts_q, rts_d;
  logic                 busy_q, busy_d;

  logic tick_c, start_edge_c, decide_c, wrap_c, maj_c, brk_c, par_err_c;

  assign line         = sync2_q;
  assign start_edge_c = (state_q == ST_IDLE) && line_prev_q && !line;
  assign decide_c     = tick_c && (os_cnt_q == OS_S2);
  assign wrap_c       = tick_c && (os_cnt_q == OS_LAST);
  assign maj_c        = majority3(smp_q[0], smp_q[1], line);
  assign brk_c        = (shreg_q == '0) && !(par_en_q && par_bit_q) && !stop1_q;
  assign par_err_c    = par_en_q && ((^shreg_q) ^ par_bit_q ^ par_odd_q);

  uart_baud_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick (
    .Clk     (Clk),
    .Rst_N   (Rst_N),
    .restart (start_edge_c),
    .div     (div_q),
    .tick_c  (tick_c)
  );

  // Next-state logic. Bits advance on the os_cnt wrap; the final stop bit
  // finishes at its decision tick so the next start edge is not missed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start_edge_c) state_d = ST_START;
      ST_START: begin
        if (decide_c && maj_c)  state_d = ST_IDLE;
        else if (wrap_c)        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (wrap_c && (bit_cnt_q == BIT_LAST)) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP1;
        end
      end
      ST_PARITY:   if (wrap_c) state_d = ST_STOP1;
      ST_STOP1: begin
        if (decide_c && !two_q)    state_d = ST_DONE;
        else if (wrap_c && two_q)  state_d = ST_STOP2;
      end
      ST_STOP2:    if (decide_c) state_d = ST_DONE;
      ST_DONE:     state_d = brk_c ? ST_BRK_WAIT : ST_IDLE;
      ST_BRK_WAIT: if (tick_c && line && hi_run_q) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    smp_d     = smp_q;
    shreg_d   = shreg_q;
    par_bit_d = par_bit_q;
    stop1_d   = stop1_q;
    frm_err_d = frm_err_q;
    hi_run_d  = 1'b0;
    div_d     = div_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    two_d     = two_q;
    rdy_d     = rdy_q;
    data_d    = data_q;
    err_d     = err_q;

    // Oversample counter only runs inside a bit period
    if ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_BRK_WAIT)) begin
      os_cnt_d = '0;
    end else if (tick_c) begin
      os_cnt_d = wrap_c ? '0 : os_cnt_q + OS_W'(1);
    end

    if (tick_c && (os_cnt_q == OS_S0)) smp_d[0] = line;
    if (tick_c && (os_cnt_q == OS_S1)) smp_d[1] = line;

    if (start_edge_c) begin
      div_d     = Baud_Div;
      par_en_d  = (Parity_Mode == PAR_EVEN) || (Parity_Mode == PAR_ODD);
      par_odd_d = (Parity_Mode == PAR_ODD);
      two_d     = Two_Stop;
      bit_cnt_d = '0;
      par_bit_d = 1'b0;
      stop1_d   = 1'b1;
      frm_err_d = 1'b0;
    end

    case (state_q)
      ST_DATA: begin
        if (decide_c) shreg_d = {maj_c, shreg_q[DATA_BITS-1:1]};
        if (wrap_c)   bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
      ST_PARITY: if (decide_c) par_bit_d = maj_c;
      ST_STOP1: begin
        if (decide_c) begin
          stop1_d   = maj_c;
          frm_err_d = !maj_c;
        end
      end
      ST_STOP2: if (decide_c) frm_err_d = frm_err_q | !maj_c;
      default: ;
    endcase

    // Break exit needs the line high across one complete tick interval
    if ((state_q == ST_BRK_WAIT) && line) begin
      hi_run_d = tick_c ? 1'b1 : hi_run_q;
    end

    // Holding register: load on DONE when free or freed this cycle
    if (state_q == ST_DONE) begin
      if (!rdy_q || Rx_Ack) begin
        rdy_d          = 1'b1;
        data_d         = shreg_q;
        err_d          = '0;
        err_d[ERR_BRK] = brk_c;
        err_d[ERR_PAR] = par_err_c;
        err_d[ERR_FRM] = frm_err_q | brk_c;
      end else begin
        err_d[ERR_OVR] = 1'b1;
      end
    end else if (rdy_q && Rx_Ack) begin
      rdy_d = 1'b0;
    end

    rts_d  = !rdy_d;
    busy_d = (state_d != ST_IDLE);
  end

  // Synchroniser idles high so reset never fakes a start edge.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
    end else begin
      sync1_q     <= Rx_In;
      sync2_q     <= sync1_q;
      line_prev_q <= sync2_q;
    end
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      smp_q     <= 2'b11;
      shreg_q   <= '0;
      par_bit_q <= 1'b0;
      stop1_q   <= 1'b1;
      frm_err_q <= 1'b0;
      hi_run_q  <= 1'b0;
      div_q     <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      two_q     <= 1'b0;
      rdy_q     <= 1'b0;
      data_q    <= '0;
      err_q     <= '0;
      rts_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      smp_q     <= smp_d;
      shreg_q   <= shreg_d;
      par_bit_q <= par_bit_d;
      stop1_q   <= stop1_d;
      frm_err_q <= frm_err_d;
      hi_run_q  <= hi_run_d;
      div_q     <= div_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      two_q     <= two_d;
      rdy_q     <= rdy_d;
      data_q    <= data_d;
      err_q     <= err_d;
      rts_q     <= rts_d;
      busy_q    <= busy_d;
    end
  end

  assign Data_Rdy_Out = rdy_q;
  assign Rx_Data_Out  = data_q;
  assign Rx_Error     = err_q;
  assign RTS          = rts_q;
  assign Busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed scenarios plus random frames
// compared against a frame-level reference model (bit list -> data/flags/latency).
module tb_uart_rx_os;

  localparam int unsigned OS = 16;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
    logic [3:0]  err;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_in;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic        rx_ack;
  logic        data_rdy;
  logic [7:0]  rx_data;
  logic [3:0]  rx_error;
  logic        rts;
  logic        busy;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  rec_t exp_q[$];
  rec_t obs_q[$];
  rec_t mon_r;
  logic        rdy_prev   = 1'b0;
  int unsigned hi_cnt     = 0;
  int unsigned last_width = 0;

  uart_rx_os #(
    .DATA_BITS  (8),
    .OVERSAMPLE (OS),
    .DIV_WIDTH  (16)
  ) dut (
    .Clk          (clk),
    .Rst_N        (rst_n),
    .Rx_In        (rx_in),
    .Baud_Div     (baud_div),
    .Parity_Mode  (parity_mode),
    .Two_Stop     (two_stop),
    .Rx_Ack       (rx_ack),
    .Data_Rdy_Out (data_rdy),
    .Rx_Data_Out  (rx_data),
    .Rx_Error     (rx_error),
    .RTS          (rts),
    .Busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record each rising edge of Data_Rdy_Out and the width of each pulse
  always @(negedge clk) begin
    if (data_rdy && !rdy_prev) begin
      mon_r.cyc  = cyc;
      mon_r.data = rx_data;
      mon_r.err  = rx_error;
      obs_q.push_back(mon_r);
      hi_cnt = 0;
    end
    if (data_rdy) hi_cnt++;
    if (!data_rdy && rdy_prev) last_width = hi_cnt;
    rdy_prev = data_rdy;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one frame as whole bit periods and, if it should be delivered,
  // queue the model's expected result.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic two,
                            input int unsigned div, input logic pflip, input logic s1,
                            input logic s2, input logic expect_out);
    logic        bits[$];
    logic        pen, podd, pbit, brk, frm, perr;
    int unsigned c0, bit_clk;
    rec_t        e;
    pen     = (pm == 2'd1) || (pm == 2'd2);
    podd    = (pm == 2'd2);
    pbit    = (^d) ^ podd ^ pflip;
    bit_clk = OS * (div + 1);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(s1);
    if (two) bits.push_back(s2);
    baud_div    = 16'(div);
    parity_mode = pm;
    two_stop    = two;
    @(posedge clk); #1;
    c0 = cyc;
    foreach (bits[i]) begin
      rx_in = bits[i];
      if (i == 1) begin
        // Config changes mid-frame must not affect this frame
        parity_mode = 2'($urandom_range(0, 3));
        two_stop    = 1'($urandom_range(0, 1));
        baud_div    = 16'($urandom_range(0, 7));
      end
      repeat (bit_clk) @(posedge clk);
      #1;
    end
    rx_in = 1'b1;
    if (expect_out) begin
      perr  = pen && ((^d) ^ pbit ^ podd);
      brk   = (d == 8'h00) && (!pen || !pbit) && !s1;
      frm   = !s1 || (two && !s2) || brk;
      // 2 sync + 1 edge detect, last stop decided at tick OS/2+2 of its bit, +2 to output
      e.cyc  = c0 + 4 + (div + 1) * (OS * (32'(bits.size()) - 1) + OS / 2 + 2);
      e.data = d;
      e.err  = {1'b0, brk, perr, frm};
      exp_q.push_back(e);
    end
  endtask

  task automatic check_next(input string tag);
    rec_t o, e;
    chk({tag, "_count"}, 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_lat"},  o.cyc,  e.cyc);
      chk({tag, "_data"}, 32'(o.data), 32'(e.data));
      chk({tag, "_err"},  32'(o.err),  32'(e.err));
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end
    obs_q.delete();
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  d;
    logic [1:0]  pm;
    logic        two, pflip, s1, s2;
    int unsigned div, c0;
    rec_t        e;

    rst_n = 1'b0; rx_in = 1'b1; rx_ack = 1'b1;
    baud_div = 16'd3; parity_mode = 2'd0; two_stop = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy",  32'(data_rdy), 32'd0);
    chk("rst_data", 32'(rx_data),  32'd0);
    chk("rst_err",  32'(rx_error), 32'd0);
    chk("rst_rts",  32'(rts),      32'd1);
    chk("rst_busy", 32'(busy),     32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(20);

    // 8N1 0xA5 with ack held
    send_frame(8'hA5, 2'd0, 1'b0, 3, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(64);
    check_next("t1");
    chk("t1_width", last_width, 32'd1);

    // 8E2 0x07, bad then good parity
    send_frame(8'h07, 2'd1, 1'b1, 3, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(64);
    check_next("t2_bad");
    send_frame(8'h07, 2'd1, 1'b1, 3, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(64);
    check_next("t2_good");

    // Start glitch of 4 ticks
    baud_div = 16'd3; parity_mode = 2'd0; two_stop = 1'b0;
    @(posedge clk); #1;
    rx_in = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rx_in = 1'b1;
    @(negedge clk);
    chk("t3_busy_hi", 32'(busy), 32'd1);
    repeat (60) @(negedge clk);
    chk("t3_busy_lo", 32'(busy), 32'd0);
    chk("t3_noframe", 32'(obs_q.size()), 32'd0);

    // Break: line low for 12 bit times, then a clean 0x5A
    @(posedge clk); #1;
    c0 = cyc;
    rx_in = 1'b0;
    e.cyc = c0 + 4 + 4 * (OS * 9 + OS / 2 + 2);
    e.data = 8'h00;
    e.err  = 4'b0101;
    exp_q.push_back(e);
    repeat (700) @(posedge clk);
    @(negedge clk);
    chk("t4_busy_brk", 32'(busy), 32'd1);
    repeat (67) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (64) @(posedge clk);
    @(negedge clk);
    chk("t4_busy_idle", 32'(busy), 32'd0);
    check_next("t4_brk");
    send_frame(8'h5A, 2'd0, 1'b0, 3, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(64);
    check_next("t4_after");

    // Overrun: two frames with no ack
    rx_ack = 1'b0;
    send_frame(8'h11, 2'd0, 1'b0, 3, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(64);
    send_frame(8'h22, 2'd0, 1'b0, 3, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(64);
    check_next("t5_first");
    @(negedge clk);
    chk("t5_data", 32'(rx_data),  32'h11);
    chk("t5_err",  32'(rx_error), 32'h8);
    chk("t5_rdy",  32'(data_rdy), 32'd1);
    chk("t5_rts",  32'(rts),      32'd0);
    @(posedge clk); #1;
    rx_ack = 1'b1;
    @(posedge clk); #1;
    rx_ack = 1'b0;
    @(negedge clk);
    chk("t5_ack_rdy",  32'(data_rdy), 32'd0);
    chk("t5_ack_rts",  32'(rts),      32'd1);
    chk("t5_ack_data", 32'(rx_data),  32'h11);

    // Reset during data bit 3 while a frame is held
    send_frame(8'h66, 2'd0, 1'b0, 3, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(64);
    check_next("t6_held");
    baud_div = 16'd3; parity_mode = 2'd0; two_stop = 1'b0;
    d = 8'h3C;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      rx_in = (i == 0) ? 1'b0 : d[i-1];
      repeat (64) @(posedge clk);
      #1;
    end
    rx_in = d[3];
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("t6_pre_busy", 32'(busy),     32'd1);
    chk("t6_pre_rdy",  32'(data_rdy), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rdy",  32'(data_rdy), 32'd0);
    chk("t6_rst_data", 32'(rx_data),  32'd0);
    chk("t6_rst_err",  32'(rx_error), 32'd0);
    chk("t6_rst_rts",  32'(rts),      32'd1);
    chk("t6_rst_busy", 32'(busy),     32'd0);
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    rx_ack = 1'b1;
    idle(64);
    send_frame(8'h3C, 2'd0, 1'b0, 3, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(64);
    check_next("t6_after");

    // Random frames: data, parity mode, stop count, divider and injected errors
    for (int n = 0; n < 16; n++) begin
      d     = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      pm    = 2'($urandom_range(0, 3));
      two   = 1'($urandom_range(0, 1));
      div   = $urandom_range(1, 3);
      pflip = ($urandom_range(0, 3) == 0);
      s1    = ($urandom_range(0, 5) != 0);
      s2    = ($urandom_range(0, 5) != 0);
      send_frame(d, pm, two, div, pflip, s1, s2, 1'b1);
      idle(2 * OS * (div + 1));
      check_next($sformatf("rnd%0d", n));
      chk($sformatf("rnd%0d_width", n), last_width, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised, oversampling UART receiver for the UART subsystem; successor to the fixed-frame RX FSM.
- Recovers asynchronous serial frames from a raw line using an internal baud-tick generator and 3-sample majority voting.
- Supports runtime-selectable parity (none/even/odd) and 1 or 2 stop bits.
- Delivers every frame, errored or not, through a valid/ack holding register with per-frame error flags, including overrun.

Parameters:
DATA_BITS, 8, data bits per frame, legal range 5..9.
OVERSAMPLE, 16, baud ticks per bit period, even and >= 8.
DIV_WIDTH, 16, width of the Baud_Div input.

Ports:
Clk  in  1  system clock
Rst_N  in  1  reset, asynchronous, active-low
Rx_In  in  1  raw serial line, idle high
Baud_Div  in  DIV_WIDTH  one tick every Baud_Div+1 clocks
Parity_Mode  in  2  0 none, 1 even, 2 odd, 3 treated as none
Two_Stop  in  1  1 = two stop bits
Rx_Ack  in  1  consumer accepts the held frame
Data_Rdy_Out  out  1  holding register valid
Rx_Data_Out  out  DATA_BITS  received data, LSB first on the line
Rx_Error  out  4  [3] overrun, [2] break, [1] parity, [0] framing
RTS  out  1  = !Data_Rdy_Out
Busy  out  1  FSM not in IDLE

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Reset values: Data_Rdy_Out=0, Rx_Data_Out=0, Rx_Error=0, RTS=1, Busy=0.
  - Synchroniser flops reset to 1; FSM resets to IDLE; tick counter resets to 0.
  - Reset mid-frame discards the partial frame.
- Rx_In passes through a 2-flop synchroniser; every reference to "line" below means the synchronised value.
- Tick generator:
  - Counter runs 0..Baud_Div and pulses tick on wrap.
  - Restarts from 0 on start-edge detection.
  - Baud_Div=0 gives a tick every clock.
- Sampling:
  - os_cnt counts ticks within a bit.
  - Bit value = majority of line samples at os_cnt OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit is decided at the OVERSAMPLE/2+1 tick; the next bit starts when os_cnt wraps at OVERSAMPLE-1.
- Frame configuration (Parity_Mode, Two_Stop, Baud_Div) is latched at start-edge detection; changes mid-frame take effect next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE, BRK_WAIT.
  - IDLE: line 1->0 edge -> START.
  - START: majority=1 -> IDLE (glitch reject, no output); majority=0 -> DATA.
  - DATA: shift DATA_BITS bits LSB-first; after the last bit -> PARITY if enabled, else STOP1.
  - PARITY: sample the parity bit -> STOP1.
  - STOP1: sample; if Two_Stop -> STOP2, else -> DONE.
  - STOP2: sample -> DONE.
  - DONE: one cycle, load holding register; break -> BRK_WAIT, else -> IDLE.
  - BRK_WAIT: wait for line=1 for one full tick -> IDLE; no new start detection until then.
- Error computation:
  - parity err = enabled && (XOR(data) ^ parity_bit ^ (mode==odd)) != 0.
  - framing err = any stop sample 0.
  - break = data==0 && parity bit (if enabled) ==0 && first stop==0; break also sets framing.
- Latency: Data_Rdy_Out rises 2 clocks after the tick that decides the last stop bit (1 to DONE, 1 to register).
- Holding register handshake:
  - Frame accepted on a Clk edge with Data_Rdy_Out=1 && Rx_Ack=1; Data_Rdy_Out drops next cycle.
  - Rx_Data_Out/Rx_Error hold their values until accepted; they hold their values after acceptance until the next load.
  - Rx_Ack while Data_Rdy_Out=0 is ignored.
- DONE while holding register full and no Ack that cycle:
  - Old data kept; new frame discarded.
  - Rx_Error[3] set (sticky until acceptance).
- DONE with Ack in the same cycle: new frame loads, Data_Rdy_Out stays 1, no overrun.

Decomposition:
- Package uart_pkg: rx_state_t enum, parity_mode_t (PAR_NONE, PAR_EVEN, PAR_ODD), error-bit index constants ERR_OVR=3, ERR_BRK=2, ERR_PAR=1, ERR_FRM=0.
- One sub-module, uart_baud_tick (counter + restart input + tick output); the rest stays in uart_rx_os.

Test Plan:
All scenarios use Baud_Div=3 and OVERSAMPLE=16 (64 clocks per bit).
1. 8N1 frame 0xA5, Rx_Ack held 1 -> Rx_Data_Out=0xA5, Rx_Error=0000, Data_Rdy_Out high exactly 1 cycle, 2 clocks after last stop decision.
2. 8E2 frame 0x07 with parity bit 0 -> Rx_Data_Out=0x07, Rx_Error=0010; repeat with parity 1 -> 0000.
3. Line low for 4 ticks then high -> Busy pulses then returns to 0, no Data_Rdy_Out.
4. Line low for 12 bit times (8N1) -> Rx_Data_Out=0x00, Rx_Error=0101, then no frame while line low; next 0x5A after line high is received clean.
5. Frames 0x11 then 0x22 with Rx_Ack=0 -> Rx_Data_Out=0x11, Rx_Error=1000, RTS=0; Ack -> Data_Rdy_Out=0, RTS=1.
6. Rst_N pulsed low during data bit 3 -> outputs at reset values asynchronously; following 0x3C frame received with Rx_Error=0000.
